// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared command codes, FSM encoding and default map for mmio_ctrl
package mmio_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RESP    = 2'd2;

    localparam logic [8:0] DEF_OUT_BASE = 9'h100;
    localparam logic [8:0] DEF_IN_BASE  = 9'h140;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } acc_kind_e;

    // Encoding 11 is reserved and behaves as no request.
    function automatic acc_kind_e decode_cmd(input logic [1:0] cmd);
        case (cmd)
            MREAD:   return ACC_READ;
            MWRITE:  return ACC_WRITE;
            default: return ACC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mmio_if.sv
// rtl/mmio_if.sv - CPU memory port bundle between the CPU and mmio_ctrl
interface mmio_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              mem_ready;

    modport master (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data,
        input  mem_ready
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data,
        output mem_ready
    );
endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - width-parametrised two-flop synchroniser with synchronous reset
module sync2 #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/mmio_ctrl.sv
// rtl/mmio_ctrl.sv - decodes CPU accesses to external RAM, output registers and synchronised inputs
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int                ADDR_W   = 9,
    parameter int                DATA_W   = 16,
    parameter int                RAM_AW   = 8,
    parameter int                N_OUT    = 2,
    parameter int                N_IN     = 2,
    parameter int                IO_W     = 10,
    parameter logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(DEF_OUT_BASE),
    parameter logic [ADDR_W-1:0] IN_BASE  = ADDR_W'(DEF_IN_BASE)
) (
    input  logic                   clk,
    input  logic                   reset,
    mmio_if.slave                  bus,
    output logic [RAM_AW-1:0]      ram_addr,
    output logic                   ram_wr,
    output logic [DATA_W-1:0]      ram_din,
    input  logic [DATA_W-1:0]      ram_dout,
    input  logic [N_IN*IO_W-1:0]   in_ports,
    output logic [N_OUT*IO_W-1:0]  out_ports,
    output logic                   bus_err
);
    logic [1:0]              state;
    logic [RAM_AW-1:0]       ram_addr_q;
    logic [DATA_W-1:0]       rdata_q;
    logic [N_OUT*IO_W-1:0]   out_q;
    logic                    bus_err_q;
    logic [N_IN*IO_W-1:0]    in_sync;

    acc_kind_e               acc;
    logic                    is_io;
    logic [N_OUT-1:0]        out_match;
    logic [N_IN-1:0]         in_match;
    logic                    io_mapped;
    logic [DATA_W-1:0]       io_rdata;

    for (genvar g = 0; g < N_IN; g++) begin : g_sync
        sync2 #(.W(IO_W)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (in_ports[g*IO_W +: IO_W]),
            .q     (in_sync[g*IO_W +: IO_W])
        );
    end

    // Output registers take precedence if the two windows are ever overlapped.
    always_comb begin
        acc       = decode_cmd(bus.mem_cmd);
        is_io     = bus.mem_addr[ADDR_W-1];
        out_match = '0;
        in_match  = '0;
        io_rdata  = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (bus.mem_addr == OUT_BASE + ADDR_W'(k)) begin
                out_match[k] = 1'b1;
                io_rdata     = DATA_W'(out_q[k*IO_W +: IO_W]);
            end
        end
        if (out_match == '0) begin
            for (int k = 0; k < N_IN; k++) begin
                if (bus.mem_addr == IN_BASE + ADDR_W'(k)) begin
                    in_match[k] = 1'b1;
                    io_rdata    = DATA_W'(in_sync[k*IO_W +: IO_W]);
                end
            end
        end
        io_mapped = (out_match != '0) || ((acc == ACC_READ) && (in_match != '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ram_addr_q <= '0;
            rdata_q    <= '0;
            out_q      <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc != ACC_NONE) begin
                        ram_addr_q <= bus.mem_addr[RAM_AW-1:0];
                        if (!is_io) begin
                            if (acc == ACC_READ) begin
                                state <= RD_WAIT;
                            end else begin
                                state   <= RESP;
                                rdata_q <= '0;
                            end
                        end else begin
                            state   <= RESP;
                            rdata_q <= (acc == ACC_READ && io_mapped) ? io_rdata : '0;
                            if (acc == ACC_WRITE) begin
                                for (int k = 0; k < N_OUT; k++) begin
                                    if (out_match[k]) begin
                                        out_q[k*IO_W +: IO_W] <= bus.write_data[IO_W-1:0];
                                    end
                                end
                            end
                            if (!io_mapped) begin
                                bus_err_q <= 1'b1;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    rdata_q <= ram_dout;
                    state   <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The RAM sees the live bus only while idle; afterwards the accepted address is held.
    assign ram_addr = (state == IDLE) ? bus.mem_addr[RAM_AW-1:0] : ram_addr_q;
    assign ram_wr   = !reset && (state == IDLE) && (acc == ACC_WRITE) && !is_io;
    assign ram_din  = bus.write_data;

    assign bus.read_data = rdata_q;
    assign bus.mem_ready = (state == RESP);
    assign out_ports     = out_q;
    assign bus_err       = bus_err_q;
endmodule

// File: tb/tb_mmio_ctrl.sv
// tb/tb_mmio_ctrl.sv - randomized self-checking bench for mmio_ctrl against a behavioural memory-map model
module tb_mmio_ctrl;
    import mmio_pkg::*;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int RAM_AW = 8;
    localparam int N_OUT  = 2;
    localparam int N_IN   = 2;
    localparam int IO_W   = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mmio_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic [RAM_AW-1:0]     ram_addr;
    logic                  ram_wr;
    logic [DATA_W-1:0]     ram_din;
    logic [DATA_W-1:0]     ram_dout;
    logic [N_IN*IO_W-1:0]  in_ports;
    logic [N_OUT*IO_W-1:0] out_ports;
    logic                  bus_err;

    mmio_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_AW(RAM_AW),
        .N_OUT(N_OUT), .N_IN(N_IN), .IO_W(IO_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_wr    (ram_wr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .in_ports  (in_ports),
        .out_ports (out_ports),
        .bus_err   (bus_err)
    );

    // External synchronous RAM with one cycle read latency.
    logic [DATA_W-1:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_wr) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    // Reference memory map.
    logic [15:0] ref_ram [256];
    logic [9:0]  ref_out [N_OUT];
    logic [9:0]  ref_in  [N_IN];
    logic        ref_err;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_out_bus();
        return 32'({ref_out[1], ref_out[0]});
    endfunction

    function automatic bit is_out(input logic [8:0] a);
        return int'(a) >= 'h100 && int'(a) < 'h100 + N_OUT;
    endfunction

    function automatic bit is_in(input logic [8:0] a);
        return int'(a) >= 'h140 && int'(a) < 'h140 + N_IN;
    endfunction

    function automatic logic [15:0] ref_read(input logic [8:0] a);
        if (!a[8])   return ref_ram[a[7:0]];
        if (is_out(a)) return 16'(ref_out[int'(a) - 'h100]);
        if (is_in(a))  return 16'(ref_in[int'(a) - 'h140]);
        return 16'h0000;
    endfunction

    task automatic access(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd,
                          output logic [15:0] rd, output int lat,
                          output logic wr_seen, output logic [7:0] ra_seen);
        @(negedge clk);
        bus.mem_cmd    = cmd;
        bus.mem_addr   = addr;
        bus.write_data = wd;
        #1;
        wr_seen = ram_wr;
        ra_seen = ram_addr;
        @(posedge clk);
        #1;
        bus.mem_cmd    = MNONE;
        bus.mem_addr   = 9'($urandom);
        bus.write_data = 16'($urandom);
        lat = 1;
        while (bus.mem_ready !== 1'b1 && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = bus.read_data;
        @(posedge clk);
    endtask

    task automatic set_inputs(input logic [9:0] p0, input logic [9:0] p1);
        @(negedge clk);
        ref_in[0] = p0;
        ref_in[1] = p1;
        in_ports  = {p1, p0};
        repeat (3) @(posedge clk);
    endtask

    // Runs one access and checks it against the model, then updates the model.
    task automatic model_op(input string tag, input logic [1:0] cmd, input logic [8:0] a, input logic [15:0] wd);
        logic [15:0] rd, exp_rd;
        int          lat;
        logic        wr_s;
        logic [7:0]  ra_s;
        bit          ram_hit;
        ram_hit = !a[8];
        exp_rd  = ref_read(a);
        access(cmd, a, wd, rd, lat, wr_s, ra_s);
        check_eq({tag, "_lat"}, lat, (ram_hit && cmd == MREAD) ? 2 : 1);
        check_eq({tag, "_ram_wr"}, wr_s, (ram_hit && cmd == MWRITE));
        if (ram_hit) check_eq({tag, "_ram_addr"}, ra_s, a[7:0]);
        if (cmd == MREAD) begin
            check_eq({tag, "_rdata"}, rd, exp_rd);
            if (!ram_hit && !is_out(a) && !is_in(a)) ref_err = 1'b1;
        end else begin
            if (ram_hit)        ref_ram[a[7:0]] = wd;
            else if (is_out(a)) ref_out[int'(a) - 'h100] = wd[9:0];
            else                ref_err = 1'b1;
        end
        check_eq({tag, "_out_ports"}, out_ports, ref_out_bus());
        check_eq({tag, "_bus_err"}, bus_err, ref_err);
    endtask

    task automatic rand_op(input bit allow_bad);
        logic [1:0] cmd;
        logic [8:0] a;
        int         sel;
        cmd = $urandom_range(0, 1) ? MREAD : MWRITE;
        sel = $urandom_range(0, allow_bad ? 3 : 2);
        case (sel)
            0:       a = {1'b0, 8'($urandom)};
            1:       a = 9'h100 + 9'($urandom_range(0, N_OUT - 1));
            2:       a = 9'h140 + 9'($urandom_range(0, N_IN - 1));
            default: begin
                a = {1'b1, 8'($urandom)};
                if (is_out(a) || is_in(a)) a = 9'h1FF;
            end
        endcase
        if (!allow_bad && sel == 2) cmd = MREAD;
        model_op("rand", cmd, a, 16'($urandom));
    endtask

    initial begin
        logic [15:0] rd;
        int          lat;
        logic        wr_s;
        logic [7:0]  ra_s;
        logic        rdy_seen, wr_seen;

        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 16'h0000;
            ref_ram[i] = 16'h0000;
        end
        for (int k = 0; k < N_OUT; k++) ref_out[k] = 10'h000;
        for (int k = 0; k < N_IN; k++)  ref_in[k]  = 10'h000;
        ref_err = 1'b0;

        // Reset with toggling inputs and a write request on the bus.
        bus.mem_cmd    = MWRITE;
        bus.mem_addr   = 9'h100;
        bus.write_data = 16'h03FF;
        in_ports       = '0;
        rdy_seen = 1'b0;
        wr_seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_ports     = 20'($urandom);
            bus.mem_addr = (i % 2 == 0) ? 9'h100 : 9'h005;
            #1;
            if (ram_wr === 1'b1) wr_seen = 1'b1;
            @(posedge clk);
            #1;
            if (bus.mem_ready === 1'b1) rdy_seen = 1'b1;
        end
        check_eq("reset_ready", rdy_seen, 1'b0);
        check_eq("reset_ram_wr", wr_seen, 1'b0);
        check_eq("reset_out_ports", out_ports, 32'h0);
        check_eq("reset_read_data", bus.read_data, 32'h0);
        check_eq("reset_bus_err", bus_err, 1'b0);
        @(negedge clk);
        reset       = 1'b0;
        bus.mem_cmd = MNONE;
        set_inputs(10'h000, 10'h000);

        // Output register write, visible with mem_ready one cycle after acceptance.
        model_op("out_wr", MWRITE, 9'h100, 16'h02A5);
        check_eq("out0_value", out_ports[9:0], 10'h2A5);
        model_op("out_rd", MREAD, 9'h100, 16'h0000);

        // Synchronised input read.
        set_inputs(10'h055, 10'h3C1);
        model_op("in1_rd", MREAD, 9'h141, 16'h0000);

        // RAM write then RAM read.
        model_op("ram_wr", MWRITE, 9'h012, 16'hBEEF);
        model_op("ram_rd", MREAD, 9'h012, 16'h0000);

        // Reserved command encoding must never start an access.
        @(negedge clk);
        bus.mem_cmd  = 2'b11;
        bus.mem_addr = 9'h012;
        rdy_seen = 1'b0;
        wr_seen  = 1'b0;
        repeat (4) begin
            #1;
            if (ram_wr === 1'b1) wr_seen = 1'b1;
            @(posedge clk);
            #1;
            if (bus.mem_ready === 1'b1) rdy_seen = 1'b1;
            @(negedge clk);
        end
        bus.mem_cmd = MNONE;
        check_eq("cmd11_ready", rdy_seen, 1'b0);
        check_eq("cmd11_ram_wr", wr_seen, 1'b0);

        // Random mapped traffic: bus_err must stay clear.
        for (int i = 0; i < 150; i++) begin
            if (i % 25 == 0) set_inputs(10'($urandom), 10'($urandom));
            rand_op(1'b0);
        end

        // Unmapped read sets the sticky error.
        model_op("unmapped", MREAD, 9'h1FF, 16'h0000);
        check_eq("unmapped_err", bus_err, 1'b1);

        // Random traffic including unmapped accesses.
        for (int i = 0; i < 150; i++) begin
            if (i % 25 == 0) set_inputs(10'($urandom), 10'($urandom));
            rand_op(1'b1);
        end
        check_eq("err_sticky", bus_err, 1'b1);

        // Reset asserted while a RAM read is in its wait state.
        model_op("pre_rst_wr", MWRITE, 9'h101, 16'h0123);
        @(negedge clk);
        bus.mem_cmd  = MREAD;
        bus.mem_addr = 9'h012;
        @(posedge clk);
        #1;
        bus.mem_cmd = MNONE;
        reset       = 1'b1;
        rdy_seen    = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready === 1'b1) rdy_seen = 1'b1;
        end
        check_eq("rst_rdwait_ready", rdy_seen, 1'b0);
        check_eq("rst_rdwait_out", out_ports, 32'h0);
        check_eq("rst_rdwait_err", bus_err, 1'b0);
        check_eq("rst_rdwait_rdata", bus.read_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < N_OUT; k++) ref_out[k] = 10'h000;
        ref_err = 1'b0;
        set_inputs(ref_in[0], ref_in[1]);

        // Recovery after reset.
        model_op("post_rst_rd", MREAD, 9'h012, 16'h0000);
        model_op("post_rst_wr", MWRITE, 9'h101, 16'h0155);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/mmio_ctrl.md
# mmio_ctrl

Parametrised memory-mapped I/O controller between the CPU memory port and the board. It decodes `mem_cmd`/`mem_addr`, routes accesses either to an external synchronous RAM or to banks of output registers (LEDs) and synchronised input ports (switches/keys), and returns read data with a `mem_ready` handshake. It replaces the fixed single-LED/single-switch tri-state decode at top level with a registered, multi-channel, wait-state-aware controller.

## Interface
- `ADDR_W`, 9, CPU address width; bit `ADDR_W-1` selects RAM (0) or I/O (1)
- `DATA_W`, 16, CPU data width
- `RAM_AW`, 8, RAM address width (`mem_addr[RAM_AW-1:0]`)
- `N_OUT`, 2, number of output registers
- `N_IN`, 2, number of input ports
- `IO_W`, 10, width of each output register and input port (≤ `DATA_W`)
- `OUT_BASE`, 9'h100, address of output register 0
- `IN_BASE`, 9'h140, address of input port 0

Ports:
- `clk` input 1: single clock
- `reset` input 1: synchronous, active-high
- `mem_cmd` input 2: `MNONE`=00, `MREAD`=01, `MWRITE`=10, 11 treated as `MNONE`
- `mem_addr` input `ADDR_W`: access address
- `write_data` input `DATA_W`: store data
- `read_data` output `DATA_W`: registered load data, valid while `mem_ready`=1
- `mem_ready` output 1: one-cycle pulse, access complete
- `ram_addr` output `RAM_AW`: RAM address
- `ram_wr` output 1: RAM write enable
- `ram_din` output `DATA_W`: RAM write data
- `ram_dout` input `DATA_W`: RAM read data, 1-cycle latency
- `in_ports` input `N_IN*IO_W`: asynchronous inputs, port k at `[k*IO_W +: IO_W]`
- `out_ports` output `N_OUT*IO_W`: output registers, same packing
- `bus_err` output 1: sticky unmapped-access flag

## Operation
- FSM states: `IDLE`, `RD_WAIT`, `RESP`.
- `IDLE`, cmd = `MNONE`: stay. Any other cmd is accepted at the clock edge; `mem_addr`/`write_data` are sampled on that edge only.
- RAM write (bit MSB=0): `ram_wr`=1 combinationally in the accepting `IDLE` cycle, `ram_addr`/`ram_din` from the bus; → `RESP`.
- RAM read: `ram_addr` driven in `IDLE`; → `RD_WAIT`; `ram_dout` captured into `read_data` at end of `RD_WAIT`; → `RESP`.
- I/O write to `OUT_BASE+k`, k<`N_OUT`: `out_ports[k]` ← `write_data[IO_W-1:0]`; → `RESP`.
- I/O read of `IN_BASE+k`, k<`N_IN`: `read_data` ← zero-extended synchronised port k; reads of `OUT_BASE+k` return the register value (readback); → `RESP`.
- Any other I/O address: write ignored, read returns 0, `bus_err` set; still → `RESP` (never hangs).
- `RESP`: `mem_ready`=1 for exactly this cycle; → `IDLE` unconditionally. CPU must present its next command (or `MNONE`) on the edge that ends `RESP`; a held command is a new access.
- Command/address changes while in `RD_WAIT`/`RESP` are ignored.
- Inputs pass through a 2-flop synchroniser per bit; reads see values ≥2 cycles old.
- `bus_err` clears only on `reset`.

## Timing
- Reset (synchronous, edge with `reset`=1): state `IDLE`, `out_ports`=0, `read_data`=0, `mem_ready`=0, `bus_err`=0, synchroniser flops 0; `ram_wr`=0. Reset mid-access aborts it: no `mem_ready`, no pending write performed after reset.
- Accepted at edge t: write/I/O read/unmapped → `mem_ready` high in cycle t+1. RAM read → `mem_ready` high in cycle t+2.
- `out_ports` update visible in cycle t+1.
- Back-to-back: max one access per 2 cycles (3 for RAM reads).

## Structure
- Package `mmio_pkg`: `MNONE`/`MREAD`/`MWRITE` constants, FSM state encoding, default `OUT_BASE`/`IN_BASE`.
- Sub-module `sync2` (width-parametrised 2-flop synchroniser), one instance per input port.

## Test plan
- Reset with `in_ports` toggling → all outputs 0, `mem_ready` never high.
- `MWRITE` 0x100 data 16'h02A5 → `out_ports[9:0]`=10'h2A5 at t+1, `mem_ready` at t+1; read 0x100 returns 16'h02A5.
- `in_ports` port1 = 10'h3C1, wait 3 cycles, `MREAD` 0x141 → `read_data`=16'h03C1 with `mem_ready` at t+1.
- `MWRITE` 0x012 data 16'hBEEF (`ram_wr` pulse, `ram_addr`=8'h12), then `MREAD` 0x012 with model RAM → `read_data`=16'hBEEF, `mem_ready` at t+2.
- `MREAD` 0x1FF → `read_data`=0, `mem_ready` t+1, `bus_err`=1 and stays 1 until reset.
- Assert `reset` in `RD_WAIT` → state `IDLE`, no `mem_ready` pulse, `out_ports` 0.
